// File: rtl/booth_divider.sv
// booth_divider: sequential signed divider, the inverse of the Booth multiplier.
// Divides a 2N-bit signed dividend Z by an N-bit signed divisor Y. The
// datapath is non-restoring division on magnitudes, one quotient bit per
// cycle, followed by a sign fix-up that truncates toward zero.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-low reset
//   start  - request, sampled only while idle
//   Z      - 2N-bit signed dividend
//   Y      - N-bit signed divisor
//   Q      - 2N-bit signed quotient (held until the next result)
//   R      - N-bit signed remainder, sign of Z or zero
//   valid  - one-cycle pulse, Q/R/dz/ovf valid
//   busy   - high whenever an operation is in flight
//   dz     - divide-by-zero flag, qualified by valid
//   ovf    - quotient overflow (Z = -2^(2N-1), Y = -1), qualified by valid
module booth_divider #(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [2*N-1:0] Z,
  input  logic signed [N-1:0]   Y,
  output logic signed [2*N-1:0] Q,
  output logic signed [N-1:0]   R,
  output logic                valid,
  output logic                busy,
  output logic                dz,
  output logic                ovf
);
  localparam int W  = 2 * N;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [N+1:0]  p_q;    // signed partial remainder
  logic [W-1:0]  a_q;    // |Z| shifting out, quotient shifting in
  logic [N:0]    d_q;    // |Y|; N+1 bits so |-2^(N-1)| fits
  logic          sz_q, sy_q;
  logic [W-1:0]  q_q;
  logic [N-1:0]  r_q;
  logic          valid_q, dz_q, ovf_q;

  logic [W-1:0]  z_abs;
  logic [N:0]    y_ext, y_abs;
  logic [N+1:0]  shift_d, p_d;
  logic [W-1:0]  a_d;
  logic [N-1:0]  r_mag, r_fix;
  logic [W-1:0]  q_fix;
  logic          ovf_fix;

  always_comb begin
    z_abs   = Z[W-1] ? -Z : Z;
    y_ext   = {Y[N-1], Y};
    y_abs   = y_ext[N] ? -y_ext : y_ext;
    // One non-restoring step: the sign of the current partial remainder
    // picks add vs subtract, the sign of the result is the quotient bit.
    shift_d = {p_q[N:0], a_q[W-1]};
    p_d     = p_q[N+1] ? shift_d + {1'b0, d_q} : shift_d - {1'b0, d_q};
    a_d     = {a_q[W-2:0], ~p_d[N+1]};
    // Corrected remainder is below |Y| <= 2^(N-1), so N-bit arithmetic suffices.
    r_mag   = p_q[N-1:0] + (p_q[N+1] ? d_q[N-1:0] : '0);
    q_fix   = (sz_q ^ sy_q) ? -a_q : a_q;
    r_fix   = sz_q ? -r_mag : r_mag;
    // Only -2^(2N-1) / -1 gives a magnitude quotient of 2^(2N-1) with equal signs.
    ovf_fix = sz_q & sy_q & (d_q == (N+1)'(1)) & (a_q == {1'b1, {(W-1){1'b0}}});
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      a_q     <= '0;
      d_q     <= '0;
      sz_q    <= 1'b0;
      sy_q    <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      valid_q <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          sz_q  <= Z[W-1];
          sy_q  <= Y[N-1];
          a_q   <= z_abs;
          d_q   <= y_abs;
          p_q   <= '0;
          cnt_q <= '0;
          // A zero divisor skips the iterations; it still passes through
          // FIX so the result lands one cycle after start.
          state_q <= (Y == '0) ? FIX : CALC;
        end
        CALC: begin
          p_q   <= p_d;
          a_q   <= a_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) state_q <= FIX;
        end
        FIX: begin
          valid_q <= 1'b1;
          state_q <= DONE;
          if (d_q == '0) begin
            q_q   <= '0;
            r_q   <= '0;
            dz_q  <= 1'b1;
            ovf_q <= 1'b0;
          end else begin
            q_q   <= q_fix;
            r_q   <= r_fix;
            dz_q  <= 1'b0;
            ovf_q <= ovf_fix;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Q     = q_q;
  assign R     = r_q;
  assign valid = valid_q;
  assign dz    = dz_q;
  assign ovf   = ovf_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_booth_divider.sv
module tb_booth_divider;
  localparam int N = 4;
  localparam int W = 2 * N;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic signed [W-1:0] Z = '0;
  logic signed [N-1:0] Y = '0;
  logic signed [W-1:0] Q;
  logic signed [N-1:0] R;
  logic                valid, busy, dz, ovf;

  int checks   = 0;
  int failures = 0;

  booth_divider #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .Z(Z), .Y(Y),
    .Q(Q), .R(R), .valid(valid), .busy(busy), .dz(dz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int z; int y; int q; int r; bit dz; bit ovf;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Issue one division and wait (bounded) for its valid pulse.
  task automatic run_div(input int z, input int y,
                         output int q, output int r, output bit odz,
                         output bit oovf, output int lat, output bit pulse1);
    @(negedge clk);
    Z = W'(z); Y = N'(y); start = 1'b1;
    @(posedge clk);  // E0
    lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        Z = W'($urandom);
        Y = N'($urandom);
      end
      if (valid) begin lat = k; break; end
    end
    q = int'(Q); r = int'(R); odz = dz; oovf = ovf;
    @(negedge clk);
    pulse1 = !valid && !busy;
  endtask

  task automatic do_vec(input string tag, input int z, input int y,
                        input int eq, input int er, input bit edz, input bit eovf);
    int q, r, lat; bit odz, oovf, p1;
    run_div(z, y, q, r, odz, oovf, lat, p1);
    chk({tag, " latency"}, lat, (y == 0) ? 1 : 2*N + 1);
    chk({tag, " Q"}, q, eq);
    chk({tag, " R"}, r, er);
    chk({tag, " dz"}, int'(odz), int'(edz));
    chk({tag, " ovf"}, int'(oovf), int'(eovf));
    chk({tag, " one-cycle valid"}, int'(p1), 1);
  endtask

  initial begin
    int nvalid, q_first, r_first, qe, re;
    bit dze, ovfe;

    vecs[0]  = '{35, 7, 5, 0, 0, 0};
    vecs[1]  = '{-24, 6, -4, 0, 0, 0};
    vecs[2]  = '{37, -5, -7, 2, 0, 0};
    vecs[3]  = '{-37, 5, -7, -2, 0, 0};
    vecs[4]  = '{-37, -8, 4, -5, 0, 0};
    vecs[5]  = '{-128, -1, -128, 0, 0, 1};
    vecs[6]  = '{100, 0, 0, 0, 1, 0};
    vecs[7]  = '{127, -8, -15, 7, 0, 0};
    vecs[8]  = '{-128, 1, -128, 0, 0, 0};
    vecs[9]  = '{0, -3, 0, 0, 0, 0};
    vecs[10] = '{-128, -8, 16, 0, 0, 0};
    vecs[11] = '{-1, 7, 0, -1, 0, 0};

    // Reset state
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("reset Q", int'(Q), 0);
    chk("reset R", int'(R), 0);
    chk("reset valid", int'(valid), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset dz", int'(dz), 0);
    chk("reset ovf", int'(ovf), 0);

    foreach (vecs[i])
      do_vec($sformatf("vec%0d", i), vecs[i].z, vecs[i].y, vecs[i].q,
             vecs[i].r, vecs[i].dz, vecs[i].ovf);

    // Outputs hold after the pulse
    repeat (5) @(negedge clk);
    chk("hold R", int'(R), -1);
    chk("hold dz", int'(dz), 0);

    // start during CALC is ignored
    @(negedge clk);
    Z = 8'sd35; Y = 4'sd7; start = 1'b1;
    @(posedge clk);
    nvalid = 0; q_first = 999; r_first = 999;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (k == 3) begin start = 1'b1; Z = -8'sd37; Y = 4'sd5; end
      if (k == 4) start = 1'b0;
      if (k == 1) chk("busy in CALC", int'(busy), 1);
      if (valid) begin
        if (nvalid == 0) begin
          q_first = int'(Q); r_first = int'(R);
          chk("ignored-start latency", k, 2*N + 1);
        end
        nvalid++;
      end
    end
    chk("ignored-start valid count", nvalid, 1);
    chk("ignored-start Q", q_first, 5);
    chk("ignored-start R", r_first, 0);

    // Reset in the middle of CALC discards the operation
    @(negedge clk);
    Z = 8'sd37; Y = -4'sd5; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid reset busy", int'(busy), 0);
    chk("mid reset Q", int'(Q), 0);
    nvalid = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (valid) nvalid++;
    end
    chk("mid reset no valid", nvalid, 0);
    do_vec("after reset", -37, 5, -7, -2, 0, 0);

    // Exhaustive sweep against truncating integer division
    for (int zi = -128; zi < 128; zi++) begin
      for (int yi = -8; yi < 8; yi++) begin
        if (yi == 0) begin
          qe = 0; re = 0; dze = 1'b1; ovfe = 1'b0;
        end else begin
          qe = zi / yi; re = zi % yi; dze = 1'b0;
          ovfe = (zi == -128) && (yi == -1);
          if (qe == 128) qe = -128;
        end
        do_vec($sformatf("ex %0d/%0d", zi, yi), zi, yi, qe, re, dze, ovfe);
      end
    end

    // Chained with a multiplier: (X*Y)/Y == X
    for (int xi = -8; xi < 8; xi++) begin
      for (int yi = -8; yi < 8; yi++) begin
        if (yi != 0)
          do_vec($sformatf("chain %0d*%0d", xi, yi), xi * yi, yi, xi, 0, 0, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
